// File: rtl/rom_readback_if.sv
// rtl/rom_readback_if.sv - ioctl upload request/response and ROM read-port signals
// master drives the HPS request and RAM read data; slave is the readback engine.
interface rom_readback_if;
    logic        UPLOAD;
    logic        RD;
    logic [24:0] ADDR;
    logic [7:0]  DOUT;
    logic        WAIT;
    logic        RD_EN;
    logic [3:0]  RD_SEL;
    logic [14:0] RD_ADDR;
    logic [7:0]  RD_DATA;
    logic [15:0] CHKSUM;
    logic [24:0] BYTE_CNT;
    logic        OVERRUN;
    logic        DONE;

    modport master (
        output UPLOAD, RD, ADDR, RD_DATA,
        input  DOUT, WAIT, RD_EN, RD_SEL, RD_ADDR, CHKSUM, BYTE_CNT, OVERRUN, DONE
    );

    modport slave (
        input  UPLOAD, RD, ADDR, RD_DATA,
        output DOUT, WAIT, RD_EN, RD_SEL, RD_ADDR, CHKSUM, BYTE_CNT, OVERRUN, DONE
    );
endinterface

// File: rtl/rom_readback.sv
// rtl/rom_readback.sv - serves ioctl upload reads from the game ROM RAM read ports
// Keeps a per-session checksum and byte count of the returned image.
module rom_readback #(
    parameter int         RAM_LATENCY = 1,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input logic           CLK,
    input logic           RESET,
    rom_readback_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAITD, CAPTURE} state_t;

    localparam int         LAT_LAST_I = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;
    localparam logic [1:0] LAT_LAST   = LAT_LAST_I[1:0];

    state_t      state;
    state_t      state_nxt;
    logic        upload_q;
    logic        mapped_q;
    logic [1:0]  lat_cnt;
    logic [3:0]  sel_q;
    logic [14:0] off_q;
    logic [7:0]  dout_q;
    logic [15:0] chksum_q;
    logic [24:0] byte_cnt_q;
    logic        overrun_q;
    logic        done_q;

    logic        dec_mapped;
    logic [3:0]  dec_sel;
    logic [14:0] dec_off;
    logic        accept;
    logic        upload_rise;
    logic [7:0]  capture_byte;

    // Region decode; the 32K banks from 0x18000 upward are all 32K-aligned,
    // so their index is simply ADDR[18:15] + 2.
    always_comb begin
        dec_mapped = 1'b1;
        dec_sel    = 4'hF;
        dec_off    = '0;
        if (bus.ADDR < 25'h10000) begin
            dec_sel = {3'b000, bus.ADDR[15]};
            dec_off = bus.ADDR[14:0];
        end else if (bus.ADDR < 25'h16000) begin
            dec_sel = 4'd2 + {2'b00, bus.ADDR[14:13]};
            dec_off = {2'b00, bus.ADDR[12:0]};
        end else if (bus.ADDR < 25'h18000) begin
            dec_mapped = 1'b0;
        end else if (bus.ADDR < 25'h60000) begin
            dec_sel = bus.ADDR[18:15] + 4'd2;
            dec_off = bus.ADDR[14:0];
        end else begin
            dec_mapped = 1'b0;
        end
    end

    assign accept       = bus.RD && bus.UPLOAD && (state == IDLE);
    assign upload_rise  = bus.UPLOAD && !upload_q;
    assign capture_byte = mapped_q ? bus.RD_DATA : FILL_BYTE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = dec_mapped ? ISSUE : CAPTURE;
            ISSUE:   state_nxt = (RAM_LATENCY == 1) ? CAPTURE : WAITD;
            WAITD:   if (lat_cnt == LAT_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Session end aborts whatever fetch is in flight.
        if (!bus.UPLOAD) state_nxt = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            upload_q   <= 1'b0;
            mapped_q   <= 1'b0;
            lat_cnt    <= '0;
            sel_q      <= 4'hF;
            off_q      <= '0;
            dout_q     <= '0;
            chksum_q   <= '0;
            byte_cnt_q <= '0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            upload_q <= bus.UPLOAD;
            done_q   <= upload_q && !bus.UPLOAD;

            if (accept) begin
                sel_q    <= dec_sel;
                off_q    <= dec_off;
                mapped_q <= dec_mapped;
            end

            lat_cnt <= (state == WAITD) ? lat_cnt + 2'd1 : 2'd0;

            if (upload_rise) begin
                chksum_q   <= '0;
                byte_cnt_q <= '0;
            end else if (state == CAPTURE && bus.UPLOAD) begin
                dout_q     <= capture_byte;
                chksum_q   <= chksum_q + {8'h00, capture_byte};
                byte_cnt_q <= byte_cnt_q + 25'd1;
            end

            if (upload_rise) begin
                overrun_q <= 1'b0;
            end else if (bus.RD && bus.UPLOAD && state != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.DOUT     = dout_q;
    assign bus.WAIT     = (state != IDLE);
    assign bus.RD_EN    = (state == ISSUE);
    assign bus.RD_SEL   = sel_q;
    assign bus.RD_ADDR  = off_q;
    assign bus.CHKSUM   = chksum_q;
    assign bus.BYTE_CNT = byte_cnt_q;
    assign bus.OVERRUN  = overrun_q;
    assign bus.DONE     = done_q;

endmodule
